// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the multdiv datapath
package multdiv_pkg;
    localparam int WIDTH = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step; a 33-bit trial subtract whose borrow picks restore or keep
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] b_abs,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);
    logic [WIDTH:0] trial;
    // shift the next dividend bit into R, trial-subtract |B|, keep the difference unless it borrowed
    always_comb begin
        trial = {r_in, q_in[WIDTH-1]} - {1'b0, b_abs};
        r_out = trial[WIDTH] ? {r_in[WIDTH-2:0], q_in[WIDTH-1]} : trial[WIDTH-1:0];
        q_out = {q_in[WIDTH-2:0], ~trial[WIDTH]};
    end
endmodule

// File: rtl/div_32.sv
// div_32: multicycle signed restoring divider, one quotient bit per clock; DIV_REMAINDER_EN adds data_remainder
module div_32
    import multdiv_pkg::*;
#(
    parameter int WIDTH = multdiv_pkg::WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
`ifdef DIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, b_q, b_d, res_q, res_d, r_nx, q_nx;
    logic neg_q, neg_d, dz_q, dz_d, ov_q, ov_d, exc_q, exc_d, rdy_q, rdy_d;
`ifdef DIV_REMAINDER_EN
    logic sa_q, sa_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    assign data_remainder = rem_q;
`endif
    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in (r_q),
        .q_in (q_q),
        .b_abs(b_q),
        .r_out(r_nx),
        .q_out(q_nx)
    );
    // state and datapath registers, all cleared by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef DIV_REMAINDER_EN
            sa_q    <= 1'b0;
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
`ifdef DIV_REMAINDER_EN
            sa_q    <= sa_d;
            rem_q   <= rem_d;
`endif
        end
    end
    // a start strobe always wins, so it also aborts a divide in RUN or DONE
    always_comb begin
        state_d = ctrl_DIV ? RUN :
                  (state_q == RUN && cnt_q == LAST) ? DONE :
                  (state_q == DONE) ? IDLE : state_q;
    end
    // capture operands on start, iterate in RUN, publish sign-corrected results in DONE
    always_comb begin
        cnt_d = cnt_q;
        r_d   = r_q;
        q_d   = q_q;
        b_d   = b_q;
        neg_d = neg_q;
        dz_d  = dz_q;
        ov_d  = ov_q;
        res_d = res_q;
        exc_d = exc_q;
        rdy_d = 1'b0;
`ifdef DIV_REMAINDER_EN
        sa_d  = sa_q;
        rem_d = rem_q;
`endif
        if (ctrl_DIV) begin
            cnt_d = '0;
            r_d   = '0;
            q_d   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
            b_d   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
            neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d  = data_operandB == '0;
            ov_d  = data_operandA == MIN_V && data_operandB == '1;
`ifdef DIV_REMAINDER_EN
            sa_d  = data_operandA[WIDTH-1];
`endif
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + 1'b1;
            r_d   = r_nx;
            q_d   = q_nx;
        end else if (state_q == DONE) begin
            rdy_d = 1'b1;
            exc_d = dz_q | ov_q;
            res_d = dz_q ? '0 : ov_q ? MIN_V : neg_q ? -q_q : q_q;
`ifdef DIV_REMAINDER_EN
            rem_d = sa_q ? -r_q : r_q;
`endif
        end
    end
endmodule
